// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH = 10;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: di = ai - bi - bin, with borrow-out.
module fs_cell (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic di,
    output logic bout
);

    assign di   = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_sub10.sv
// Bit-serial ripple-borrow subtractor, LSB first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_sub10
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow
);

    localparam int CW = clog2(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] d_reg;
    logic             br_reg;
    logic             borrow_reg;
    logic [CW-1:0]    cnt_reg;

    logic             di;
    logic             bout;
    logic             accept;
    logic             last_bit;
    logic             out_fire;

    fs_cell u_fs_cell (
        .ai   (a_sh_reg[0]),
        .bi   (b_sh_reg[0]),
        .bin  (br_reg),
        .di   (di),
        .bout (bout)
    );

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_bit = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)   state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // The A register doubles as the result register: each difference bit
    // enters at the MSB as the consumed minuend bit leaves at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            d_reg      <= '0;
            borrow_reg <= 1'b0;
        end else if (accept) begin
            a_sh_reg <= a;
            b_sh_reg <= b;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg <= {di, a_sh_reg[WIDTH-1:1]};
            b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
            br_reg   <= bout;
            cnt_reg  <= cnt_reg + 1'b1;
            if (last_bit) begin
                d_reg      <= {di, a_sh_reg[WIDTH-1:1]};
                borrow_reg <= bout;
            end
        end
    end

    assign d      = d_reg;
    assign borrow = borrow_reg;

endmodule
